// File: rtl/sha256_msg_loader.sv
// Byte-stream front-end for sha256_core: loads a padded single-block message, starts the core, streams the digest.
// Optional `SHA_LOADER_BTC_EN adds an i_btc port for 80-byte bitcoin-header (double SHA-256) mode.
module sha256_msg_loader #(
   parameter logic [6:0] W_BASE      = 7'd0,
   parameter logic [6:0] STATUS_ADDR = 7'd80,
   parameter logic [6:0] DIGEST_BASE = 7'd84
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_s_valid,
   input  logic [7:0] i_s_data,
   input  logic       i_s_last,
   output logic       o_s_ready,
   output logic       o_m_valid,
   output logic [7:0] o_m_data,
   output logic       o_m_last,
   input  logic       i_m_ready,
   output logic [6:0] o_core_addr,
   output logic [7:0] o_core_data,
   output logic       o_core_we,
   input  logic [7:0] i_core_data,
   input  logic       i_core_irq,
`ifdef SHA_LOADER_BTC_EN
   input  logic       i_btc,
`endif
   output logic       o_err,
   output logic       o_busy
);

   localparam int unsigned CNT_W = 7;
   localparam int unsigned LEN_W = 8;
   localparam int unsigned ADR_W = 7;
   localparam logic [CNT_W-1:0] MAX_MSG  = 7'd55;
   localparam logic [CNT_W-1:0] BTC_LEN  = 7'd80;
   localparam logic [CNT_W-1:0] LAST_PAD = 7'd63;
   localparam logic [CNT_W-1:0] LAST_DIG = 7'd31;

   typedef enum logic [2:0] {
      IDLE, LOAD, PAD, GO, WAIT_LO, WAIT_HI, READ, DRAIN
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc, msg_limit;
   logic [LEN_W-1:0]   len_q, len_d;
   logic               btc_q, btc_d, btc_in;
   logic               s_ready_d, m_valid_d, m_last_d, core_we_d, err_d;
   logic [ADR_W-1:0]   core_addr_d;
   logic [7:0]         core_data_d;
   logic               s_hs, m_hs;

`ifdef SHA_LOADER_BTC_EN
   assign btc_in = i_btc;
`else
   assign btc_in = 1'b0;
`endif

   // Message byte k lands so that W0 occupies the top word; header tail bytes 64..79 go below it.
   function automatic logic [ADR_W-1:0] msg_addr(input logic [CNT_W-1:0] k);
      if (k < 7'd64) return 7'({1'b0, W_BASE} + 8'd63 - {1'b0, k});
      return 7'({1'b0, W_BASE} + 8'd143 - {1'b0, k});
   endfunction

   function automatic logic [ADR_W-1:0] dig_addr(input logic [CNT_W-1:0] j);
      return 7'(DIGEST_BASE + 7'd31 - j);
   endfunction

   // 0x80 terminator, zero fill, then the bit length L*8 in the last two bytes.
   function automatic logic [7:0] pad_byte(input logic [CNT_W-1:0] idx, input logic [LEN_W-1:0] len);
      if ({1'b0, idx} == len) return 8'h80;
      if (idx == 7'd62)       return {5'b00000, len[7:5]};
      if (idx == LAST_PAD)    return {len[4:0], 3'b000};
      return 8'h00;
   endfunction

   assign s_hs      = o_s_ready & i_s_valid;
   assign m_hs      = o_m_valid & i_m_ready;
   assign cnt_inc   = cnt_q + 7'd1;
   assign msg_limit = btc_q ? BTC_LEN : MAX_MSG;
   assign o_m_data  = i_core_data;

   // Next-state and next-output logic; every registered output is computed here.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      len_d       = len_q;
      btc_d       = btc_q;
      core_we_d   = 1'b0;
      core_addr_d = DIGEST_BASE;
      core_data_d = 8'h00;
      m_valid_d   = 1'b0;
      m_last_d    = 1'b0;
      err_d       = 1'b0;
      s_ready_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (s_hs) begin
               btc_d       = btc_in;
               core_we_d   = 1'b1;
               core_addr_d = msg_addr(7'd0);
               core_data_d = i_s_data;
               cnt_d       = 7'd1;
               len_d       = 8'd1;
               if (!i_s_last) begin
                  state_d = LOAD;
               end else if (btc_in) begin
                  err_d   = 1'b1;
                  cnt_d   = 7'd0;
               end else begin
                  state_d = PAD;
               end
            end
         end
         LOAD: begin
            if (s_hs) begin
               if (cnt_q == msg_limit) begin
                  // Over-length byte: dropped, rest of the message is drained.
                  cnt_d   = 7'd0;
                  err_d   = i_s_last;
                  state_d = i_s_last ? IDLE : DRAIN;
               end else begin
                  core_we_d   = 1'b1;
                  core_addr_d = msg_addr(cnt_q);
                  core_data_d = i_s_data;
                  cnt_d       = cnt_inc;
                  len_d       = 8'(cnt_inc);
                  if (i_s_last) begin
                     if (!btc_q) begin
                        state_d = PAD;
                     end else if (cnt_inc == BTC_LEN) begin
                        state_d = GO;
                     end else begin
                        err_d   = 1'b1;
                        cnt_d   = 7'd0;
                        state_d = IDLE;
                     end
                  end
               end
            end
         end
         PAD: begin
            core_we_d   = 1'b1;
            core_addr_d = msg_addr(cnt_q);
            core_data_d = pad_byte(cnt_q, len_q);
            if (cnt_q == LAST_PAD) begin
               cnt_d   = 7'd0;
               state_d = GO;
            end else begin
               cnt_d   = cnt_inc;
            end
         end
         GO: begin
            core_we_d   = 1'b1;
            core_addr_d = STATUS_ADDR;
            core_data_d = btc_q ? 8'h03 : 8'h01;
            cnt_d       = 7'd0;
            state_d     = WAIT_LO;
         end
         WAIT_LO: begin
            if (!i_core_irq) state_d = WAIT_HI;
         end
         WAIT_HI: begin
            if (i_core_irq) begin
               state_d     = READ;
               cnt_d       = 7'd0;
               m_valid_d   = 1'b1;
               core_addr_d = dig_addr(7'd0);
            end
         end
         READ: begin
            // Address and flags hold while the sink stalls, keeping o_m_data stable.
            m_valid_d   = 1'b1;
            core_addr_d = dig_addr(cnt_q);
            m_last_d    = (cnt_q == LAST_DIG);
            if (m_hs) begin
               if (cnt_q == LAST_DIG) begin
                  state_d     = IDLE;
                  cnt_d       = 7'd0;
                  m_valid_d   = 1'b0;
                  m_last_d    = 1'b0;
                  core_addr_d = DIGEST_BASE;
               end else begin
                  cnt_d       = cnt_inc;
                  core_addr_d = dig_addr(cnt_inc);
                  m_last_d    = (cnt_inc == LAST_DIG);
               end
            end
         end
         DRAIN: begin
            if (s_hs && i_s_last) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Input is only taken when the core reports completed, so a busy core blocks new messages.
      case (state_d)
         IDLE:        s_ready_d = i_core_irq;
         LOAD, DRAIN: s_ready_d = 1'b1;
         default:     s_ready_d = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         btc_q       <= 1'b0;
         o_s_ready   <= 1'b0;
         o_m_valid   <= 1'b0;
         o_m_last    <= 1'b0;
         o_core_we   <= 1'b0;
         o_core_addr <= DIGEST_BASE;
         o_core_data <= 8'h00;
         o_err       <= 1'b0;
         o_busy      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         btc_q       <= btc_d;
         o_s_ready   <= s_ready_d;
         o_m_valid   <= m_valid_d;
         o_m_last    <= m_last_d;
         o_core_we   <= core_we_d;
         o_core_addr <= core_addr_d;
         o_core_data <= core_data_d;
         o_err       <= err_d;
         o_busy      <= (state_d != IDLE);
      end
   end

endmodule

// File: tb/tb_sha256_msg_loader.sv
// Directed bench for sha256_msg_loader with a behavioural sha256_core (byte memory + SHA-256 compression).
module tb_sha256_msg_loader;

   localparam logic [6:0] STATUS = 7'd80;
   localparam int         DBASE  = 84;
   localparam logic [255:0] ABC_DIG =
      256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
   localparam logic [255:0] H_INIT =
      256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
   localparam logic [31:0] K_TAB [0:63] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   logic       i_clk = 1'b0;
   logic       i_rst, i_s_valid, i_s_last, i_m_ready, i_core_irq;
   logic [7:0] i_s_data, i_core_data;
   logic       o_s_ready, o_m_valid, o_m_last, o_core_we, o_err, o_busy;
   logic [7:0] o_m_data, o_core_data;
   logic [6:0] o_core_addr;

   int tests_run = 0;
   int tests_failed = 0;
   int we_cnt = 0, err_cnt = 0, stat_cnt = 0;
   logic [7:0] stat_last = 8'h00;

   logic [7:0]   cmem [0:127];
   logic [7:0]   msg_buf [0:127];
   logic         core_busy = 1'b0;
   int           core_timer = 0;
   logic [255:0] core_dig = '0;

   always #5 i_clk = ~i_clk;

   sha256_msg_loader dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_s_valid   (i_s_valid),
      .i_s_data    (i_s_data),
      .i_s_last    (i_s_last),
      .o_s_ready   (o_s_ready),
      .o_m_valid   (o_m_valid),
      .o_m_data    (o_m_data),
      .o_m_last    (o_m_last),
      .i_m_ready   (i_m_ready),
      .o_core_addr (o_core_addr),
      .o_core_data (o_core_data),
      .o_core_we   (o_core_we),
      .i_core_data (i_core_data),
      .i_core_irq  (i_core_irq),
`ifdef SHA_LOADER_BTC_EN
      .i_btc       (1'b0),
`endif
      .o_err       (o_err),
      .o_busy      (o_busy)
   );

   function automatic logic [31:0] ror(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
      logic [31:0] w [0:63];
      logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
      for (int i = 0; i < 16; i++) w[6'(i)] = 32'(blk >> (32 * (15 - i)));
      for (int i = 16; i < 64; i++)
         w[6'(i)] = w[6'(i-16)] + w[6'(i-7)]
                  + (ror(w[6'(i-15)], 7) ^ ror(w[6'(i-15)], 18) ^ (w[6'(i-15)] >> 3))
                  + (ror(w[6'(i-2)], 17) ^ ror(w[6'(i-2)], 19) ^ (w[6'(i-2)] >> 10));
      {a, b, c, d, e, f, g, h} = H_INIT;
      for (int i = 0; i < 64; i++) begin
         t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[6'(i)] + w[6'(i)];
         t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
      end
      return {a + H_INIT[255:224], b + H_INIT[223:192], c + H_INIT[191:160], d + H_INIT[159:128],
              e + H_INIT[127:96],  f + H_INIT[95:64],   g + H_INIT[63:32],   h + H_INIT[31:0]};
   endfunction

   // Core's view of the block: message byte k sits at address 63-k.
   function automatic logic [511:0] mem_block();
      logic [511:0] b = '0;
      for (int k = 0; k < 64; k++) b = {b[503:0], cmem[7'(63 - k)]};
      return b;
   endfunction

   function automatic logic [7:0] dig_byte(input logic [255:0] d, input int j);
      return 8'(d >> (8 * (31 - j)));
   endfunction

   // Behavioural core: byte-write memory, start on status bit 0, completed bit drops while hashing.
   assign i_core_irq  = ~core_busy;
   assign i_core_data = cmem[o_core_addr];

   always @(posedge i_clk) begin
      if (o_core_we === 1'b1) begin
         cmem[o_core_addr] <= o_core_data;
         if (o_core_addr == STATUS && o_core_data[0]) begin
            core_busy  <= 1'b1;
            core_timer <= 20;
         end
      end
      if (core_busy) begin
         if (core_timer == 1) core_dig <= sha256_blk(mem_block());
         if (core_timer == 0) begin
            for (int j = 0; j < 32; j++) cmem[7'(DBASE + 31 - j)] <= dig_byte(core_dig, j);
            core_busy <= 1'b0;
         end else begin
            core_timer <= core_timer - 1;
         end
      end
   end

   always @(negedge i_clk) begin
      if (o_core_we === 1'b1) begin
         we_cnt++;
         if (o_core_addr == STATUS) begin
            stat_cnt++;
            stat_last = o_core_data;
         end
      end
      if (o_err === 1'b1) err_cnt++;
   end

   task automatic send_byte(input logic [7:0] d, input logic l, output bit ok);
      ok = 1'b0;
      i_s_valid = 1'b1; i_s_data = d; i_s_last = l;
      for (int g = 0; g < 300 && !ok; g++) begin
         if (o_s_ready === 1'b1) ok = 1'b1;
         @(negedge i_clk);
      end
      i_s_valid = 1'b0; i_s_last = 1'b0;
   endtask

   task automatic send_msg(input int n, output bit ok);
      bit b_ok;
      ok = 1'b1;
      for (int k = 0; k < n; k++) begin
         send_byte(msg_buf[7'(k)], k == n - 1, b_ok);
         if (!b_ok) begin ok = 1'b0; break; end
      end
   endtask

   // mode 0: sink always ready; mode 1: ready pattern 1,0,0,1 repeating.
   task automatic recv_digest(input int mode, output logic [255:0] got, output int last_bad,
                              output int stab_bad, output bit ok);
      int n = 0;
      logic [7:0] held = 8'h00;
      bit have_held = 1'b0;
      got = '0; last_bad = 0; stab_bad = 0;
      for (int cyc = 0; cyc < 2000 && n < 32; cyc++) begin
         i_m_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
         if (o_m_valid === 1'b1) begin
            if (have_held && o_m_data !== held) stab_bad++;
            if (i_m_ready) begin
               got = {got[247:0], o_m_data};
               if (o_m_last !== (n == 31)) last_bad++;
               n++;
               have_held = 1'b0;
            end else begin
               held = o_m_data;
               have_held = 1'b1;
            end
         end
         @(negedge i_clk);
      end
      i_m_ready = 1'b0;
      ok = (n == 32);
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_s_valid = 1'b0; i_s_data = 8'h00; i_s_last = 1'b0; i_m_ready = 1'b0;
      repeat (3) @(negedge i_clk);
      tests_run++;
      if ({o_s_ready, o_m_valid, o_m_last, o_core_we, o_err, o_busy} !== 6'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: got %b expected 000000",
                  {o_s_ready, o_m_valid, o_m_last, o_core_we, o_err, o_busy});
      end
      tests_run++;
      if (o_core_addr !== 7'd84) begin
         tests_failed++; $display("FAIL reset_addr: got %0d expected 84", o_core_addr);
      end
      tests_run++;
      if (o_core_data !== 8'h00) begin
         tests_failed++; $display("FAIL reset_core_data: got %h expected 00", o_core_data);
      end
      tests_run++;
      if (o_m_data !== 8'h00) begin
         tests_failed++; $display("FAIL reset_m_data: got %h expected 00", o_m_data);
      end
      i_rst = 1'b0;
      @(negedge i_clk);
      tests_run++;
      if (o_s_ready !== 1'b1) begin
         tests_failed++; $display("FAIL reset_ready_idle: got %b expected 1", o_s_ready);
      end
   endtask

   task automatic test_abc();
      int we0 = we_cnt, st0 = stat_cnt, lb, sb, nz = 0;
      logic [255:0] got;
      bit ok, rok;
      msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
      send_msg(3, ok);
      recv_digest(0, got, lb, sb, rok);
      tests_run++;
      if (!ok || !rok || got !== ABC_DIG) begin
         tests_failed++; $display("FAIL abc_digest: got %h expected %h (send %0d recv %0d)", got, ABC_DIG, ok, rok);
      end
      tests_run++;
      if (lb != 0) begin tests_failed++; $display("FAIL abc_last: %0d misplaced last flags, expected 0", lb); end
      tests_run++;
      if ({cmem[63], cmem[62], cmem[61], cmem[60]} !== 32'h61626380) begin
         tests_failed++;
         $display("FAIL abc_msg_words: got %h expected 61626380", {cmem[63], cmem[62], cmem[61], cmem[60]});
      end
      tests_run++;
      if ({cmem[1], cmem[0]} !== 16'h0018) begin
         tests_failed++; $display("FAIL abc_length: got %h expected 0018", {cmem[1], cmem[0]});
      end
      for (int i = 2; i < 60; i++) if (cmem[7'(i)] !== 8'h00) nz++;
      tests_run++;
      if (nz != 0) begin tests_failed++; $display("FAIL abc_zero_fill: %0d nonzero bytes, expected 0", nz); end
      tests_run++;
      if (we_cnt - we0 != 65) begin
         tests_failed++; $display("FAIL abc_write_count: got %0d expected 65", we_cnt - we0);
      end
      tests_run++;
      if (stat_cnt - st0 != 1 || stat_last !== 8'h01) begin
         tests_failed++;
         $display("FAIL abc_status_write: got %0d writes data %h expected 1 write data 01", stat_cnt - st0, stat_last);
      end
      tests_run++;
      if (o_busy !== 1'b0 || o_m_valid !== 1'b0) begin
         tests_failed++; $display("FAIL abc_idle_after: busy %b valid %b expected 0 0", o_busy, o_m_valid);
      end
   endtask

   task automatic test_len55();
      logic [511:0] blk = '0;
      logic [255:0] exp_dig, got;
      int lb, sb;
      bit ok, rok;
      for (int k = 0; k < 55; k++) begin
         msg_buf[7'(k)] = 8'h61;
         blk = {blk[503:0], 8'h61};
      end
      blk = {blk[503:0], 8'h80, 48'h0, 8'h01, 8'hb8};
      exp_dig = sha256_blk(blk);
      send_msg(55, ok);
      recv_digest(0, got, lb, sb, rok);
      tests_run++;
      if (!ok || !rok || got !== exp_dig) begin
         tests_failed++; $display("FAIL len55_digest: got %h expected %h", got, exp_dig);
      end
      tests_run++;
      if ({cmem[8], cmem[1], cmem[0]} !== 24'h8001b8) begin
         tests_failed++; $display("FAIL len55_padding: got %h expected 8001b8", {cmem[8], cmem[1], cmem[0]});
      end
   endtask

   task automatic test_overflow();
      int we0 = we_cnt, st0 = stat_cnt, er0 = err_cnt;
      bit ok;
      for (int k = 0; k < 60; k++) msg_buf[7'(k)] = 8'(k);
      send_msg(60, ok);
      repeat (2) @(negedge i_clk);
      tests_run++;
      if (!ok || err_cnt - er0 != 1) begin
         tests_failed++; $display("FAIL ovf_err_pulse: got %0d pulses (send %0d) expected 1", err_cnt - er0, ok);
      end
      tests_run++;
      if (we_cnt - we0 != 55 || stat_cnt != st0) begin
         tests_failed++;
         $display("FAIL ovf_writes: got %0d writes %0d status expected 55 and 0", we_cnt - we0, stat_cnt - st0);
      end
      tests_run++;
      if ({cmem[9], cmem[8]} !== 16'h3680) begin
         tests_failed++; $display("FAIL ovf_byte56_dropped: got %h expected 3680", {cmem[9], cmem[8]});
      end
      tests_run++;
      if (o_busy !== 1'b0 || o_s_ready !== 1'b1) begin
         tests_failed++; $display("FAIL ovf_idle_after: busy %b ready %b expected 0 1", o_busy, o_s_ready);
      end
   endtask

   task automatic test_backpressure();
      logic [255:0] got;
      int lb, sb;
      bit ok, rok;
      msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
      send_msg(3, ok);
      recv_digest(1, got, lb, sb, rok);
      tests_run++;
      if (!ok || !rok || got !== ABC_DIG) begin
         tests_failed++; $display("FAIL bp_digest: got %h expected %h", got, ABC_DIG);
      end
      tests_run++;
      if (sb != 0 || lb != 0) begin
         tests_failed++; $display("FAIL bp_stable: %0d data changes while stalled, %0d bad last, expected 0 0", sb, lb);
      end
   endtask

   task automatic test_reset_midop();
      logic [255:0] got;
      int lb, sb, bad = 0;
      bit ok, rok;
      msg_buf[0] = 8'h61; msg_buf[1] = 8'h62; msg_buf[2] = 8'h63;
      send_msg(3, ok);
      for (int g = 0; g < 500 && i_core_irq; g++) @(negedge i_clk);
      tests_run++;
      if (!ok || i_core_irq !== 1'b0) begin
         tests_failed++; $display("FAIL midop_core_started: irq %b send %0d expected irq 0", i_core_irq, ok);
      end
      repeat (3) @(negedge i_clk);
      i_rst = 1'b1;
      @(negedge i_clk);
      i_rst = 1'b0;
      tests_run++;
      if (o_busy !== 1'b0 || o_s_ready !== 1'b0 || o_m_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL midop_reset_idle: busy %b ready %b valid %b expected 0 0 0", o_busy, o_s_ready, o_m_valid);
      end
      for (int g = 0; g < 100 && !i_core_irq; g++) begin
         if (o_s_ready !== 1'b0) bad++;
         @(negedge i_clk);
      end
      tests_run++;
      if (bad != 0 || i_core_irq !== 1'b1) begin
         tests_failed++; $display("FAIL midop_ready_blocked: %0d ready cycles while busy, irq %b, expected 0 1", bad, i_core_irq);
      end
      send_msg(3, ok);
      recv_digest(0, got, lb, sb, rok);
      tests_run++;
      if (!ok || !rok || got !== ABC_DIG) begin
         tests_failed++; $display("FAIL midop_abc_digest: got %h expected %h", got, ABC_DIG);
      end
   endtask

   initial begin
      for (int i = 0; i < 128; i++) begin
         cmem[7'(i)] = 8'h00;
         msg_buf[7'(i)] = 8'h00;
      end
      test_reset();
      test_abc();
      test_len55();
      test_overflow();
      test_backpressure();
      test_reset_midop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
